// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-strobed horizontal/vertical counters with combinational
// sync, visible-area and clamped coordinate decode, plus end-of-frame pulses.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_active,
  output logic       o_blanking,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic [9:0] o_h_cnt,
  output logic [9:0] o_v_cnt,
  output logic       o_animate,
  output logic       o_screenend
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START   = H_ACTIVE + H_FP;
  localparam int HS_END     = HS_START + H_SYNC;
  localparam int VS_START   = V_ACTIVE + V_FP;
  localparam int VS_END     = VS_START + V_SYNC;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;
  logic       h_vis;
  logic       v_vis;
  logic       h_sync_win;
  logic       v_sync_win;

  assign h_last = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last = (v_cnt == 10'(V_TOTAL - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (i_pix_stb) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign h_vis      = (h_cnt < 10'(H_ACTIVE));
  assign v_vis      = (v_cnt < 10'(V_ACTIVE));
  assign h_sync_win = (h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END));
  assign v_sync_win = (v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END));

  assign o_hs       = h_sync_win ? SYNC_POL : ~SYNC_POL;
  assign o_vs       = v_sync_win ? SYNC_POL : ~SYNC_POL;
  assign o_active   = h_vis && v_vis;
  assign o_blanking = ~o_active;
  assign o_x        = h_vis ? h_cnt : 10'(H_ACTIVE - 1);
  assign o_y        = v_vis ? v_cnt[8:0] : 9'(V_ACTIVE - 1);
  assign o_h_cnt    = h_cnt;
  assign o_v_cnt    = v_cnt;

  // Pulses mark the strobe that leaves the last pixel; reset suppresses them.
  assign o_animate   = i_pix_stb && !i_rst &&
                       (h_cnt == 10'(H_ACTIVE - 1)) && (v_cnt == 10'(V_ACTIVE - 1));
  assign o_screenend = i_pix_stb && !i_rst && h_last && v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default-timing instances of both sync
// polarities plus a shrunken-timing instance so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb = 1'b0;
  always #5 clk = ~clk;

  logic       hs[3], vs[3], act[3], blk[3], anim[3], scr[3];
  logic [9:0] hc[3], vc[3], xx[3];
  logic [8:0] yy[3];

  vga_timing_gen dut_d (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_hs(hs[0]), .o_vs(vs[0]), .o_active(act[0]), .o_blanking(blk[0]),
    .o_x(xx[0]), .o_y(yy[0]), .o_h_cnt(hc[0]), .o_v_cnt(vc[0]),
    .o_animate(anim[0]), .o_screenend(scr[0]));

  vga_timing_gen #(.SYNC_POL(1'b1)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_hs(hs[1]), .o_vs(vs[1]), .o_active(act[1]), .o_blanking(blk[1]),
    .o_x(xx[1]), .o_y(yy[1]), .o_h_cnt(hc[1]), .o_v_cnt(vc[1]),
    .o_animate(anim[1]), .o_screenend(scr[1]));

  // Small raster: 8+2+3+2 = 15 pixels per line, 6+1+2+1 = 10 lines per frame.
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_hs(hs[2]), .o_vs(vs[2]), .o_active(act[2]), .o_blanking(blk[2]),
    .o_x(xx[2]), .o_y(yy[2]), .o_h_cnt(hc[2]), .o_v_cnt(vc[2]),
    .o_animate(anim[2]), .o_screenend(scr[2]));

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       an;
    logic       sc;
  } ie_t;

  typedef struct packed {
    ie_t e2;
    ie_t e1;
    ie_t e0;
  } exp_t;

  exp_t sb[$];
  int   mh[3] = '{0, 0, 0};
  int   mv[3] = '{0, 0, 0};
  int   n_chk = 0;
  int   n_fail = 0;
  int   anim_cnt = 0;
  int   scr_cnt = 0;

  task automatic chk(input string name, input int id, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", name, id, $time, got, want);
    end
  endtask

  // Hand-derived windows for each instance's raster.
  function automatic void exp_dec(input int id, input int h, input int v,
                                  output logic ehs, output logic evs, output logic eact,
                                  output int ex, output int ey);
    int   ha, va, hs0, hs1, vs0, vs1;
    logic pol;
    if (id == 2) begin
      ha = 8; va = 6; hs0 = 10; hs1 = 12; vs0 = 7; vs1 = 8; pol = 1'b0;
    end else begin
      ha = 640; va = 480; hs0 = 656; hs1 = 751; vs0 = 490; vs1 = 491; pol = (id == 1);
    end
    ehs  = (h >= hs0 && h <= hs1) ? pol : !pol;
    evs  = (v >= vs0 && v <= vs1) ? pol : !pol;
    eact = (h < ha) && (v < va);
    ex   = (h < ha) ? h : ha - 1;
    ey   = (v < va) ? v : va - 1;
  endfunction

  function automatic ie_t mk(input int id, input logic s, input logic r);
    ie_t e;
    int  ah, av, sh, sv;
    if (id == 2) begin ah = 7; av = 5; sh = 14; sv = 9; end
    else begin ah = 639; av = 479; sh = 799; sv = 524; end
    e.h  = 10'(mh[id]);
    e.v  = 10'(mv[id]);
    e.an = s && !r && mh[id] == ah && mv[id] == av;
    e.sc = s && !r && mh[id] == sh && mv[id] == sv;
    return e;
  endfunction

  task automatic step(input logic s, input logic r);
    exp_t e;
    int   ht, vt;
    @(posedge clk);
    #1;
    stb = s;
    rst = r;
    e.e0 = mk(0, s, r);
    e.e1 = mk(1, s, r);
    e.e2 = mk(2, s, r);
    sb.push_back(e);
    for (int i = 0; i < 3; i++) begin
      ht = (i == 2) ? 15 : 800;
      vt = (i == 2) ? 10 : 525;
      if (r) begin
        mh[i] = 0; mv[i] = 0;
      end else if (s) begin
        if (mh[i] == ht - 1) begin
          mh[i] = 0;
          mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
        end else begin
          mh[i] = mh[i] + 1;
        end
      end
    end
  endtask

  task automatic chk_inst(input int id, input ie_t e);
    logic ehs, evs, eact;
    int   ex, ey;
    exp_dec(id, int'(e.h), int'(e.v), ehs, evs, eact, ex, ey);
    chk("h_cnt", id, int'(hc[id]), int'(e.h));
    chk("v_cnt", id, int'(vc[id]), int'(e.v));
    chk("hs", id, int'(hs[id]), int'(ehs));
    chk("vs", id, int'(vs[id]), int'(evs));
    chk("active", id, int'(act[id]), int'(eact));
    chk("blanking", id, int'(blk[id]), int'(!eact));
    chk("x", id, int'(xx[id]), ex);
    chk("y", id, int'(yy[id]), ey);
    chk("animate", id, int'(anim[id]), int'(e.an));
    chk("screenend", id, int'(scr[id]), int'(e.sc));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (anim[2]) anim_cnt++;
    if (scr[2]) scr_cnt++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_inst(0, e.e0);
      chk_inst(1, e.e1);
      chk_inst(2, e.e2);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, s0;
    repeat (3) step(1'b0, 1'b1);

    // One default line at one strobe per four clocks.
    for (int i = 0; i < 800; i++) begin
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
    @(negedge clk); #1;
    chk("line_wrap_h", 0, int'(hc[0]), 0);
    chk("line_wrap_v", 0, int'(vc[0]), 1);
    chk("line_wrap_v_pol1", 1, int'(vc[1]), 1);

    // Full small frame with irregular strobe gaps.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    @(negedge clk); #1;
    a0 = anim_cnt;
    s0 = scr_cnt;
    for (int i = 0; i < 150; i++) begin
      step(1'b1, 1'b0);
      if (i % 7 == 3) step(1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
    @(negedge clk); #1;
    chk("frame_animate_count", 2, anim_cnt - a0, 1);
    chk("frame_screenend_count", 2, scr_cnt - s0, 1);
    chk("frame_end_h", 2, int'(hc[2]), 0);
    chk("frame_end_v", 2, int'(vc[2]), 0);

    // Freeze at the last visible pixel with no strobes.
    step(1'b0, 1'b1);
    repeat (82) step(1'b1, 1'b0);
    repeat (1000) step(1'b0, 1'b0);
    @(negedge clk); #1;
    chk("frozen_h", 2, int'(hc[2]), 7);
    chk("frozen_v", 2, int'(vc[2]), 5);
    chk("frozen_animate", 2, int'(anim[2]), 0);
    step(1'b1, 1'b0);

    // Clamped coordinates in the porch corner (h=12, v=8).
    step(1'b0, 1'b1);
    repeat (132) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk); #1;
    chk("corner_x", 2, int'(xx[2]), 7);
    chk("corner_y", 2, int'(yy[2]), 5);
    chk("corner_active", 2, int'(act[2]), 0);
    chk("corner_blanking", 2, int'(blk[2]), 1);

    // Reset colliding with the screen-end strobe at (14,9).
    repeat (17) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    @(negedge clk); #1;
    chk("rst_pri_h", 2, int'(hc[2]), 0);
    chk("rst_pri_v", 2, int'(vc[2]), 0);
    chk("rst_mid_h", 0, int'(hc[0]), 0);
    chk("rst_mid_v", 0, int'(vc[0]), 0);

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("scoreboard_drained", 0, sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 0, sync asserted level (0 = active-low).
REQ-010 SHALL have port i_clk, input, 1, single system clock; all logic on its rising edge.
REQ-011 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-012 SHALL have port i_pix_stb, input, 1, one-clock pixel-advance strobe.
REQ-013 SHALL have port o_hs, output, 1, horizontal sync.
REQ-014 SHALL have port o_vs, output, 1, vertical sync.
REQ-015 SHALL have port o_active, output, 1, high while in the visible area.
REQ-016 SHALL have port o_blanking, output, 1, inverse of o_active.
REQ-017 SHALL have port o_x, output, 10, visible pixel column, clamped.
REQ-018 SHALL have port o_y, output, 9, visible line, clamped.
REQ-019 SHALL have port o_h_cnt, output, 10, raw horizontal counter.
REQ-020 SHALL have port o_v_cnt, output, 10, raw vertical counter.
REQ-021 SHALL have port o_animate, output, 1, one-clock pulse at end of the visible frame.
REQ-022 SHALL have port o_screenend, output, 1, one-clock pulse at end of the full frame.

Function
REQ-023 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-024 SHALL hold h_cnt and v_cnt in registers that change only on clocks where i_pix_stb=1 and i_rst=0.
REQ-025 SHALL advance h_cnt by 1 per strobe, wrapping from H_TOTAL-1 to 0.
REQ-026 SHALL advance v_cnt by 1 only on the strobe where h_cnt wraps, and SHALL wrap v_cnt from V_TOTAL-1 to 0 on that same strobe.
REQ-027 SHALL hold both counters unchanged when i_pix_stb=0, including across consecutive strobes separated by any gap.
REQ-028 SHALL order each line as: active 0..639, front porch 640..655, sync 656..751, back porch 752..799 (default values).
REQ-029 SHALL order each frame as: active 0..479, front porch 480..489, sync 490..491, back porch 492..524 (default values).
REQ-030 SHALL drive o_hs = SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, and ~SYNC_POL otherwise; o_vs SHALL follow the same rule on v_cnt.
REQ-031 SHALL drive o_active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
REQ-032 SHALL drive o_x = min(h_cnt, H_ACTIVE-1) and o_y = min(v_cnt, V_ACTIVE-1).
REQ-033 SHALL decode o_hs, o_vs, o_active, o_blanking, o_x and o_y combinationally from the counter registers, with zero cycles of latency relative to them.
REQ-034 SHALL assert o_animate for exactly one clock when i_pix_stb=1, h_cnt=H_ACTIVE-1 and v_cnt=V_ACTIVE-1.
REQ-035 SHALL assert o_screenend for exactly one clock when i_pix_stb=1, h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
REQ-036 SHALL assert neither pulse on any clock where i_pix_stb=0, even when the counter conditions are met.

Reset
REQ-037 SHALL, on a clock with i_rst=1, load h_cnt=0 and v_cnt=0; reset SHALL take priority over i_pix_stb.
REQ-038 SHALL, while in reset, hold o_hs=o_vs=~SYNC_POL, o_active=1, o_blanking=0, o_x=0, o_y=0, o_animate=0 and o_screenend=0.
REQ-039 SHALL, when reset is asserted mid-frame (any counter value), return to 0/0 on the next edge, with no pulse emitted on that clock.

Verification
REQ-040 Reset, then 800 strobes (strobe every 4th clock) -> h_cnt wraps 799->0; v_cnt=1; o_hs low exactly for h_cnt 656..751.
REQ-041 Run one full frame (420000 strobes) -> exactly one o_animate at (639,479) and one o_screenend at (799,524); both counters end at 0; o_vs low exactly for lines 490..491.
REQ-042 Hold i_pix_stb=0 for 1000 clocks at h_cnt=639, v_cnt=479 -> counters frozen; o_animate stays 0.
REQ-043 At h_cnt=700, v_cnt=500 -> o_x=639, o_y=479, o_active=0, o_blanking=1.
REQ-044 Assert i_rst together with i_pix_stb at h_cnt=799, v_cnt=524 -> next state 0/0; o_screenend=0.
REQ-045 With SYNC_POL=1, run one line -> o_hs high exactly for h_cnt 656..751, low otherwise.
